// File: rtl/mem_stage_sram_ctrl.sv
// mem_stage_sram_ctrl
//   Memory stage of the 5-stage ARM pipeline. Performs 32-bit loads/stores on
//   a 16-bit external SRAM as two half-word accesses (low half, then high half).
//   It stalls upstream stages through `ready` while an access is in flight, and
//   it holds the MEM/WB pipeline register that feeds write-back.
//
// Parameters
//   SRAM_WAIT  cycles each half-word access is held on the bus (>= 1)
//   ADDR_BASE  byte offset subtracted from ALU_result before SRAM addressing
//
// Ports
//   clk, rst          clock (rising edge); asynchronous active-high reset
//   WB_EN_in          write-back enable from EXE/MEM
//   MEM_R_EN/MEM_W_EN load / store request (both set is treated as a load)
//   ALU_result        byte address, or the result of a non-memory instruction
//   Val_Rm            store data
//   Dest              destination register index
//   ready             combinational; 0 freezes all upstream stages
//   WB_EN, MEM_R_EN_out, ALU_result_out, Mem_read_value, Dest_out
//                     MEM/WB register outputs to write-back
//   SRAM_ADDR         half-word address
//   SRAM_DQ           bidirectional SRAM data bus, driven only while SRAM_WE_N=0
//   SRAM_WE_N         SRAM write enable, active-low
module mem_stage_sram_ctrl #(
  parameter int unsigned SRAM_WAIT = 2,
  parameter logic [31:0] ADDR_BASE = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_EN_in,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] ALU_result,
  input  logic [31:0] Val_Rm,
  input  logic [3:0]  Dest,
  output logic        ready,
  output logic        WB_EN,
  output logic        MEM_R_EN_out,
  output logic [31:0] ALU_result_out,
  output logic [31:0] Mem_read_value,
  output logic [3:0]  Dest_out,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam int unsigned CW = (SRAM_WAIT > 1) ? $clog2(SRAM_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(SRAM_WAIT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   lo_q, hi_q;

  logic          mem_req, is_store;
  logic [31:0]   offs;
  logic [17:0]   lo_addr, hi_addr;
  logic [15:0]   wdata;
  logic          cap_lo, cap_hi;
  logic          unused_offs;

  assign mem_req  = MEM_R_EN | MEM_W_EN;
  // Both enables set is an illegal encoding; it is treated as a load.
  assign is_store = MEM_W_EN & ~MEM_R_EN;

  // Word index is (ALU_result - base) >> 2; bits above 17 wrap silently.
  assign offs        = ALU_result - ADDR_BASE;
  assign lo_addr     = {offs[18:2], 1'b0};
  assign hi_addr     = {offs[18:2], 1'b1};
  assign unused_offs = ^{offs[31:19], offs[1:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready     = 1'b0;
    SRAM_WE_N = 1'b1;
    SRAM_ADDR = '0;
    wdata     = '0;
    cap_lo    = 1'b0;
    cap_hi    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          state_d = LO;
          cnt_d   = WAIT_LOAD;
        end else begin
          ready = 1'b1;
        end
      end
      LO: begin
        SRAM_ADDR = lo_addr;
        SRAM_WE_N = ~is_store;
        wdata     = Val_Rm[15:0];
        if (cnt_q == '0) begin
          cap_lo  = ~is_store;
          state_d = HI;
          cnt_d   = WAIT_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HI: begin
        SRAM_ADDR = hi_addr;
        SRAM_WE_N = ~is_store;
        wdata     = Val_Rm[31:16];
        if (cnt_q == '0) begin
          cap_hi  = ~is_store;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign SRAM_DQ = (!SRAM_WE_N) ? wdata : 16'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      lo_q           <= '0;
      hi_q           <= '0;
      WB_EN          <= 1'b0;
      MEM_R_EN_out   <= 1'b0;
      ALU_result_out <= '0;
      Mem_read_value <= '0;
      Dest_out       <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (cap_lo) lo_q <= SRAM_DQ;
      if (cap_hi) hi_q <= SRAM_DQ;
      if (ready) begin
        WB_EN          <= WB_EN_in;
        MEM_R_EN_out   <= MEM_R_EN;
        ALU_result_out <= ALU_result;
        Dest_out       <= Dest;
        if (state_q == DONE && MEM_R_EN) Mem_read_value <= {hi_q, lo_q};
      end else begin
        // Stall: push a bubble into write-back, hold the data fields.
        WB_EN        <= 1'b0;
        MEM_R_EN_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
module tb_mem_stage_sram_ctrl;
  localparam int unsigned W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_EN_in, MEM_R_EN, MEM_W_EN;
  logic [31:0] ALU_result, Val_Rm;
  logic [3:0]  Dest;
  logic        ready, WB_EN, MEM_R_EN_out, SRAM_WE_N;
  logic [31:0] ALU_result_out, Mem_read_value;
  logic [3:0]  Dest_out;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] dq;

  mem_stage_sram_ctrl #(.SRAM_WAIT(W), .ADDR_BASE(32'd1024)) dut (
    .clk(clk), .rst(rst), .WB_EN_in(WB_EN_in), .MEM_R_EN(MEM_R_EN),
    .MEM_W_EN(MEM_W_EN), .ALU_result(ALU_result), .Val_Rm(Val_Rm), .Dest(Dest),
    .ready(ready), .WB_EN(WB_EN), .MEM_R_EN_out(MEM_R_EN_out),
    .ALU_result_out(ALU_result_out), .Mem_read_value(Mem_read_value),
    .Dest_out(Dest_out), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(dq), .SRAM_WE_N(SRAM_WE_N)
  );

  always #5 clk = ~clk;

  // External SRAM: reads out whenever a load is requested and no write is active.
  logic [15:0] sram [0:262143];
  assign dq = (MEM_R_EN && SRAM_WE_N) ? sram[SRAM_ADDR] : 16'bz;
  always @(posedge clk) if (!SRAM_WE_N) sram[SRAM_ADDR] <= dq;

  // Expected outputs, maintained by the model below.
  logic        e_ready, e_we_n, e_wb, e_mr;
  logic [17:0] e_addr;
  logic [15:0] e_dq;
  logic [31:0] e_alu, e_mrv;
  logic [3:0]  e_dest;
  logic        chk_en = 1'b0;
  logic [31:0] mmem [int unsigned];  // architectural word memory, by word index

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 32'(ready), 32'(e_ready));
      chk("we_n", 32'(SRAM_WE_N), 32'(e_we_n));
      chk("addr", 32'(SRAM_ADDR), 32'(e_addr));
      if (!e_we_n) chk("dq", 32'(dq), 32'(e_dq));
      chk("wb_en", 32'(WB_EN), 32'(e_wb));
      chk("mem_r_en_out", 32'(MEM_R_EN_out), 32'(e_mr));
      chk("alu_out", ALU_result_out, e_alu);
      chk("mem_read_value", Mem_read_value, e_mrv);
      chk("dest_out", 32'(Dest_out), 32'(e_dest));
    end
  end

  function automatic int unsigned word_of(input logic [31:0] alu);
    logic [31:0] t;
    t = alu - 32'd1024;
    return (t / 4) % 131072;
  endfunction

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    WB_EN_in = 0; MEM_R_EN = 0; MEM_W_EN = 0; ALU_result = 0; Val_Rm = 0; Dest = 0;
    e_ready = 1; e_we_n = 1; e_addr = 0; e_dq = 0;
    e_wb = 0; e_mr = 0; e_alu = 0; e_mrv = 0; e_dest = 0;
    repeat (cycles) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Applies one instruction (starting just after a rising edge) and advances
  // the model until the instruction has been accepted by the MEM/WB register.
  // abort_k >= 0 asserts reset at that stall cycle instead of completing.
  task automatic do_instr(input logic wb, input logic r, input logic w,
                          input logic [31:0] alu, input logic [31:0] vrm,
                          input logic [3:0] d, input int abort_k);
    int unsigned wi;
    logic store;
    wi = word_of(alu);
    store = w && !r;
    WB_EN_in = wb; MEM_R_EN = r; MEM_W_EN = w; ALU_result = alu; Val_Rm = vrm; Dest = d;
    if (r || w) begin
      for (int k = 0; k <= int'(2 * W); k++) begin
        if (k == abort_k) begin
          do_reset(2);
          return;
        end
        e_ready = 0;
        if (k == 0) begin
          e_addr = 0; e_we_n = 1;
        end else if (k <= int'(W)) begin
          e_addr = 18'(wi * 2); e_we_n = !store; e_dq = vrm[15:0];
        end else begin
          e_addr = 18'(wi * 2 + 1); e_we_n = !store; e_dq = vrm[31:16];
        end
        @(posedge clk); #1;
        e_wb = 0; e_mr = 0;
      end
    end
    e_ready = 1; e_we_n = 1; e_addr = 0;
    @(posedge clk); #1;
    e_wb = wb; e_mr = r; e_alu = alu; e_dest = d;
    if (r) e_mrv = mmem.exists(wi) ? mmem[wi] : 32'd0;
    else if (w) mmem[wi] = vrm;
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) sram[i] = 16'h0000;
    sram[2] = 16'h5678;
    sram[3] = 16'h1234;
    mmem[1] = 32'h1234_5678;
    rst = 1'b0;
    WB_EN_in = 0; MEM_R_EN = 0; MEM_W_EN = 0; ALU_result = 0; Val_Rm = 0; Dest = 0;
    #1;
    chk_en = 1'b1;
    do_reset(2);

    // Non-memory instruction: zero added latency.
    do_instr(1, 0, 0, 32'h55, 32'h0, 4'd3, -1);
    chk("pin_nonmem_alu", ALU_result_out, 32'h55);
    chk("pin_nonmem_dest", 32'(Dest_out), 32'd3);
    chk("pin_nonmem_wb", 32'(WB_EN), 32'd1);

    // Store 0xDEADBEEF at base address -> half-words 0 and 1.
    do_instr(0, 0, 1, 32'd1024, 32'hDEAD_BEEF, 4'd5, -1);
    chk("pin_store_lo", 32'(sram[0]), 32'h0000_BEEF);
    chk("pin_store_hi", 32'(sram[1]), 32'h0000_DEAD);

    // Load from preloaded words 2/3.
    do_instr(1, 1, 0, 32'd1028, 32'h0, 4'd7, -1);
    chk("pin_load", Mem_read_value, 32'h1234_5678);

    // Store immediately followed by load of the same address.
    do_instr(0, 0, 1, 32'd1032, 32'hA5A5_5A5A, 4'd1, -1);
    do_instr(1, 1, 0, 32'd1032, 32'h0, 4'd2, -1);
    chk("pin_store_load", Mem_read_value, 32'hA5A5_5A5A);

    // Non-memory after a load: Mem_read_value must hold.
    do_instr(1, 0, 0, 32'h99, 32'h0, 4'd4, -1);

    // Both enables set: treated as a load, nothing written.
    do_instr(1, 1, 1, 32'd1024, 32'hFFFF_FFFF, 4'd2, -1);
    chk("pin_illegal_load", Mem_read_value, 32'hDEAD_BEEF);

    // Address wrap aliases onto word 0.
    do_instr(0, 0, 1, 32'd1024 + 32'd4 * 32'd131072, 32'hCAFE_F00D, 4'd6, -1);
    chk("pin_wrap_lo", 32'(sram[0]), 32'h0000_F00D);
    do_instr(1, 1, 0, 32'd1024, 32'h0, 4'd8, -1);
    chk("pin_wrap_load", Mem_read_value, 32'hCAFE_F00D);

    // Reset during the first HI cycle of a store.
    do_instr(0, 0, 1, 32'd1036, 32'h1111_2222, 4'd9, int'(W) + 1);
    repeat (3) do_instr(0, 0, 0, 32'h0, 32'h0, 4'd0, -1);

    // One more full load after the abort.
    do_instr(1, 1, 0, 32'd1028, 32'h0, 4'd10, -1);
    do_instr(0, 0, 0, 32'h0, 32'h0, 4'd0, -1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
Memory stage of the 5-stage ARM pipeline, directly downstream of the execute stage. Consumes the execute stage's ALU result (address), the store data and the control bits. Performs 32-bit loads and stores on a 16-bit external SRAM as two half-word accesses, and stalls the pipeline through `ready` while an access is in flight. Contains the MEM/WB pipeline register that feeds write-back.

Parameters:
- SRAM_WAIT, default 2: cycles each half-word access is held on the SRAM bus. Must be at least 1.
- ADDR_BASE, default 1024: byte offset subtracted from ALU_result before SRAM addressing.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- WB_EN_in  in  1  write-back enable from the EXE/MEM register
- MEM_R_EN  in  1  load request
- MEM_W_EN  in  1  store request
- ALU_result  in  32  byte address, or the result for non-memory instructions
- Val_Rm  in  32  store data
- Dest  in  4  destination register index
- ready  out  1  combinational; 0 freezes all upstream stages
- WB_EN  out  1  registered, to write-back
- MEM_R_EN_out  out  1  registered; selects the load value in write-back
- ALU_result_out  out  32  registered
- Mem_read_value  out  32  registered load data
- Dest_out  out  4  registered
- SRAM_ADDR  out  18  half-word address
- SRAM_DQ  inout  16  SRAM data bus
- SRAM_WE_N  out  1  SRAM write enable, active-low

Behaviour:
- Reset:
  - Asynchronous; `rst`=1 immediately forces state IDLE.
  - All registered outputs are 0, SRAM_WE_N=1, SRAM_ADDR=0, SRAM_DQ high-Z, capture registers 0.
  - Reset mid-access abandons the access. A store may be half-written; this is accepted.
- Addressing:
  - word = (ALU_result − ADDR_BASE) >> 2, computed at 32 bits, then truncated.
  - Low half address = {word[16:0],1'b0}; high half address = {word[16:0],1'b1}, truncated to 18 bits. Wrap-around is silent.
- FSM states: IDLE, LO, HI, DONE. A wait counter is loaded with SRAM_WAIT−1 on entry to LO and to HI.
- IDLE:
  - If MEM_R_EN|MEM_W_EN=1: ready=0, go to LO.
  - Otherwise ready=1 and the MEM/WB register captures the inputs this edge. Non-memory instructions have zero added latency.
- LO: SRAM_ADDR = low half address.
  - Store: SRAM_WE_N=0, SRAM_DQ = Val_Rm[15:0].
  - Load: SRAM_WE_N=1, DQ high-Z, low half captured from SRAM_DQ on the last LO cycle.
  - Go to HI when the counter reaches 0. ready=0.
- HI: same as LO using the high half address and Val_Rm[31:16]; the load captures the high half. Go to DONE when the counter reaches 0. ready=0.
- DONE:
  - ready=1, SRAM_WE_N=1, DQ high-Z.
  - MEM/WB register captures the inputs plus Mem_read_value = {hi,lo}.
  - Next state IDLE.
- Latency: a memory instruction holds ready=0 for 2·SRAM_WAIT+1 cycles; ready=1 arrives on the following cycle.
- Upstream stage registers must not advance while ready=0. The inputs are therefore stable for the whole access.
- While ready=0 the MEM/WB register loads a bubble: WB_EN=0 and MEM_R_EN_out=0; other fields hold.
- Back-to-back memory instructions: DONE→IDLE gives exactly one ready=1 cycle between them. The new request is detected in IDLE on the next cycle.
- MEM_R_EN and MEM_W_EN both 1 is illegal and is treated as a load; no SRAM write occurs.
- SRAM_WE_N is never 0 outside LO/HI of a store. SRAM_DQ is driven only while SRAM_WE_N=0.
- Mem_read_value holds its last value after a store or a non-memory instruction.

Test Plan:
- Reset, then non-memory instruction (WB_EN_in=1, ALU_result=0x55, Dest=3) → ready=1 throughout; next edge WB_EN=1, ALU_result_out=0x55, Dest_out=3.
- Store ALU_result=1024, Val_Rm=0xDEADBEEF, SRAM_WAIT=2:
  - ready=0 for cycles 0–4.
  - SRAM_ADDR=0, DQ=0xBEEF, WE_N=0 for cycles 1–2.
  - SRAM_ADDR=1, DQ=0xDEAD for cycles 3–4.
  - ready=1 in cycle 5; WB_EN output 0 throughout.
- Load ALU_result=1028 with SRAM model holding [2]=0x5678, [3]=0x1234 → SRAM_ADDR 2 then 3, WE_N=1; after DONE, Mem_read_value=0x12345678, MEM_R_EN_out=1, WB_EN=1.
- Store immediately followed by load of the same address → exactly one ready=1 cycle between the two stalls; load returns the stored word.
- Assert rst during HI of a store → SRAM_WE_N=1 and DQ high-Z the same cycle; after release, state IDLE and ready=1 when no request is pending.
- Address wrap: ALU_result=1024+4·(2^17) → SRAM_ADDR=0 then 1.
